// File: rtl/shift_seq.sv
// Iterative 16-bit shift/rotate unit: one operand, count and opcode are captured on start, then shifted over several cycles.
// Optional build macro SHIFT_SEQ_FAST_EN: power-of-two steps (k = popcount(Cnt)) instead of single steps (k = Cnt).
module shift_seq #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int O = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  input  logic [O-1:0] Op,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] dat_q, dat_d;
  logic [C-1:0] rem_q, rem_d;
  logic [O-1:0] op_q, op_d;
  logic [N-1:0] step_dat;
  logic [C-1:0] step_amt;

  // Opcode 00 rotl, 01 shl, 10 rotr, 11 shr; a is always 1..N-1 here.
  function automatic logic [N-1:0] step_by(input logic [N-1:0] d, input logic [O-1:0] o,
                                           input int unsigned a);
    logic [N-1:0] r;
    case (o)
      2'b00:   r = (d << a) | (d >> (N - a));
      2'b01:   r = d << a;
      2'b10:   r = (d >> a) | (d << (N - a));
      default: r = d >> a;
    endcase
    return r;
  endfunction

`ifdef SHIFT_SEQ_FAST_EN
  // Highest set bit of rem picks the step; later iterations override earlier ones.
  always_comb begin
    step_dat = dat_q;
    step_amt = '0;
    for (int i = 0; i < C; i++) begin
      if (rem_q[i]) begin
        step_dat = step_by(dat_q, op_q, 32'd1 << i);
        step_amt = C'(1) << i;
      end
    end
  end
`else
  always_comb begin
    step_dat = step_by(dat_q, op_q, 32'd1);
    step_amt = C'(1);
  end
`endif

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      SHIFT: begin
        dat_d   = step_dat;
        rem_d   = rem_q - step_amt;
        state_d = (rem_d == '0) ? DONE : SHIFT;
      end
      default: begin
        if (start) begin
          dat_d   = In;
          rem_d   = Cnt;
          op_d    = Op;
          state_d = (Cnt == '0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dat_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign Out  = dat_q;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: the driver queues expected results, the monitor checks them on done.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] In = '0;
  logic [3:0]  Cnt = '0;
  logic [1:0]  Op = '0;
  logic        busy, done;
  logic [15:0] Out;

  shift_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .In(In), .Cnt(Cnt), .Op(Op),
    .busy(busy), .done(done), .Out(Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic [15:0] res;
    int          k;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cnt = 0;

  // Reference computed with integer arithmetic on powers of two.
  function automatic logic [15:0] model(input logic [15:0] x, input int c, input logic [1:0] op);
    longint v = longint'(x);
    longint p = longint'(1) << c;
    longint r;
    case (op)
      2'b00:   r = (v * p) % 65536 + v / (65536 / p);
      2'b01:   r = (v * p) % 65536;
      2'b10:   r = v / p + (v * (65536 / p)) % 65536;
      default: r = v / p;
    endcase
    return r[15:0];
  endfunction

  function automatic int steps(input logic [3:0] c);
`ifdef SHIFT_SEQ_FAST_EN
    return $countones(c);
`else
    return int'(c);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy && done) check("busy_done_overlap", 32'd1, 32'd0);
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("txn in=0x%04h cnt=%0d op=%0d out=0x%04h busy_cycles=%0d", e.in, e.cnt, e.op, Out, busy_cnt);
          check("result", 32'(Out), 32'(e.res));
          check("latency", 32'(busy_cnt), 32'(e.k));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a falling edge; waits for the unit to accept, then pulses start for one cycle.
  task automatic issue(input logic [15:0] in, input logic [3:0] cnt, input logic [1:0] op);
    exp_t e;
    int t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("issue_timeout", 32'd1, 32'd0);
    start = 1'b1; In = in; Cnt = cnt; Op = op;
    e.in = in; e.cnt = cnt; e.op = op;
    e.res = model(in, int'(cnt), op);
    e.k = steps(cnt);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out", 32'(Out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h8001, 4'd1, 2'b00);
    drain();
    issue(16'h00FF, 4'd4, 2'b01);
    drain();
    issue(16'h0001, 4'd15, 2'b10);
    drain();
    issue(16'hF000, 4'd0, 2'b11);
    drain();

    // Ignored mid-operation start, then back-to-back start in the DONE cycle.
    issue(16'hF0F0, 4'd4, 2'b11);
    start = 1'b1; In = 16'h1234; Cnt = 4'd3; Op = 2'b00;
    @(negedge clk);
    start = 1'b0;
    issue(16'h0001, 4'd2, 2'b01);
    drain();

    // Asynchronous abort during SHIFT.
    issue(16'hABCD, 4'd10, 2'b00);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out", 32'(Out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h1357, 4'd7, 2'b10);
    drain();

    for (int i = 0; i < 150; i++) begin
      issue(16'($urandom), 4'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Iterative shift/rotate execution unit for the 16-bit datapath. It sits between the execute-stage operand muxing and the writeback mux. It accepts one operand, a 4-bit count and a 2-bit opcode on a `start` pulse, then applies single-position (or power-of-two) shift steps to an internal register over multiple cycles. It signals completion with a one-cycle `done`. Sharing one small shift step across cycles replaces a full combinational barrel shifter in area-constrained builds.

## Interface
- `N`, 16, operand/result width
- `C`, 4, count width; valid counts are 0..2^C-1
- `O`, 2, opcode width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only while `busy`=0
- `In`  in  N  operand, captured on an accepted `start`
- `Cnt`  in  C  shift amount, captured on an accepted `start`
- `Op`  in  O  opcode, captured on an accepted `start`
- `busy`  out  1  high while in SHIFT
- `done`  out  1  one-cycle pulse; `Out` holds the final result
- `Out`  out  N  internal data register

## Operation
- Opcodes:
  - 00: rotate left.
  - 01: shift left logical, zero fill.
  - 10: rotate right.
  - 11: shift right logical, zero fill.
- State register `{IDLE, SHIFT, DONE}`; data register `dat[N-1:0]`; remaining count `rem[C-1:0]`; opcode register `op`.
- IDLE/DONE with `start`=1:
  - `dat`←`In`, `rem`←`Cnt`, `op`←`Op`.
  - Next state is DONE if `Cnt`==0, else SHIFT.
- IDLE/DONE with `start`=0: DONE→IDLE; IDLE stays IDLE; `dat` is held.
- SHIFT, each cycle:
  - step size s = 1 (see Configuration).
  - `dat`←`dat` shifted/rotated by s per `op`; `rem`←`rem`-s.
  - Next state is DONE when `rem`-s==0, else SHIFT.
- `start` while `busy`=1 is ignored. It is neither queued nor aborting.
- `Out`=`dat` at all times. Values shown during SHIFT are partial results and must not be consumed.
- Rotates and shifts are modulo-free: a count of N-1 is legal and exact; no count reaches N because C=4.

## Timing
- Reset values: state=IDLE, `dat`=0, `rem`=0, `busy`=0, `done`=0, `Out`=0x0000.
- Let E0 be the edge at which `start` is accepted, and k the number of steps.
  - `busy`=1 in the cycles after E0..E(k-1).
  - `done`=1 and the final `Out` appear in the cycle after Ek.
  - k=0 (`Cnt`=0): `done`=1 in the cycle after E0, with `Out`=`In`.
- `done` is high for exactly one cycle. `Out` holds the result until the next accepted `start`.
- Back-to-back operation: `start` during a DONE cycle is accepted. The new operation begins with no idle bubble, and `done` still pulses for the finished operation.
- Reset mid-operation: async abort to the reset values; no `done` is produced.
- `busy` and `done` are never high together.

## Configuration
- `SHIFT_SEQ_FAST_EN` undefined:
  - s=1 every SHIFT cycle.
  - k=`Cnt`; worst-case latency 15 cycles.
- `SHIFT_SEQ_FAST_EN` defined:
  - s is the highest set bit of `rem` (8, 4, 2 or 1), implemented as a 4-way step select.
  - k=popcount(`Cnt`); worst-case latency 4 cycles.
- Functional result is identical in both builds; only latency differs.

## Test plan
- Reset, then `In`=0x8001, `Cnt`=1, `Op`=00 → `done` after E1; `Out`=0x0003; `busy` high for one cycle.
- `In`=0x00FF, `Cnt`=4, `Op`=01 → `Out`=0x0FF0.
  - Without the macro: `done` after E4.
  - With the macro: `done` after E1.
- `In`=0x0001, `Cnt`=15, `Op`=10 → `Out`=0x0002.
  - Without the macro: `done` after E15.
  - With the macro: `done` after E4.
- `In`=0xF000, `Cnt`=0, `Op`=11 → `done` after E0; `Out`=0xF000; `busy` never asserted.
- Start `In`=0xF0F0, `Cnt`=4, `Op`=11:
  - Pulse `start` with `In`=0x1234 mid-operation → ignored; result is 0x0F0F.
  - A second `start` in the DONE cycle with `In`=0x0001, `Cnt`=2, `Op`=01 → accepted with no bubble; result is 0x0004.
- Assert `rst_n`=0 during SHIFT → outputs immediately go to 0, IDLE, no `done`.
  - After release, a fresh `start` completes normally.
